// File: rtl/wash_pkg.sv
// Shared definitions for the wash sequencer: phase encoding, default durations
// and the timed-phase predicate.
package wash_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StWash  = 3'd2,
    StDrain = 3'd3,
    StRinse = 3'd4,
    StSpin  = 3'd5,
    StDone  = 3'd6
  } wash_state_e;

  localparam logic [7:0] FillTDef  = 8'd20;
  localparam logic [7:0] WashTDef  = 8'd200;
  localparam logic [7:0] RinseTDef = 8'd100;
  localparam logic [7:0] SpinTDef  = 8'd150;
  localparam logic [7:0] DrainTDef = 8'd30;
  localparam logic [7:0] RevTDef   = 8'd10;

  function automatic logic is_timed(input wash_state_e s);
    return (s != StIdle) && (s != StDone);
  endfunction

endpackage

// File: rtl/wash_reverser.sv
// Wash motor reversal counter: flips the FWD/REV select every REV_T enabled cycles.
// dir is the select to be registered at the coming edge (0 = FWD, 1 = REV).
module wash_reverser
  import wash_pkg::*;
#(
  parameter logic [7:0] REV_T = RevTDef
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic dir
);

  logic [7:0] cnt;
  logic       dir_q;
  logic       wrap;

  assign wrap = en && (cnt == REV_T - 8'd1);
  assign dir  = clr ? 1'b0 : (wrap ? ~dir_q : dir_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (en) begin
      cnt   <= wrap ? 8'd0 : cnt + 8'd1;
      dir_q <= dir;
    end
  end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine programme sequencer driving an external phase timer.
// Optional WASH_LID_LOCK_EN adds LID_CLOSED / LID_LOCK interlock ports.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter logic [7:0]  FILL_T  = FillTDef,
  parameter logic [7:0]  WASH_T  = WashTDef,
  parameter logic [7:0]  RINSE_T = RinseTDef,
  parameter logic [7:0]  SPIN_T  = SpinTDef,
  parameter logic [7:0]  DRAIN_T = DrainTDef,
  parameter logic [7:0]  REV_T   = RevTDef,
  parameter int unsigned RINSES  = 2
) (
  input  logic       CP,
  input  logic       CLR_,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       ABORT,
  input  logic       TMR_DONE,
`ifdef WASH_LID_LOCK_EN
  input  logic       LID_CLOSED,
  output logic       LID_LOCK,
`endif
  output logic [7:0] TMR_RS,
  output logic       TMR_LD,
  output logic       TMR_EN,
  output logic       WATER_IN,
  output logic       MOTOR_FWD,
  output logic       MOTOR_REV,
  output logic       DRAIN_V,
  output logic [2:0] PHASE,
  output logic       COMPLETE
);

  localparam logic [2:0] RinseMax = 3'(RINSES);

  wash_state_e state, state_d;
  logic [2:0]  rinse_cnt, rinse_d;
  logic        abort_flag, abort_d;
  logic        start_ok, paused, adv, run, dir, rev_en, rev_clr;
  logic [7:0]  dur;

`ifdef WASH_LID_LOCK_EN
  assign start_ok = START && LID_CLOSED;
  assign paused   = PAUSE || !LID_CLOSED;
`else
  assign start_ok = START;
  assign paused   = PAUSE;
`endif

  // TMR_EN is low while paused, so a late expiry can only land on the first paused edge.
  assign adv     = TMR_EN && TMR_DONE;
  assign run     = is_timed(state_d) && !paused;
  assign rev_clr = (state_d == StWash) && (state != StWash);
  assign rev_en  = (state == StWash) && TMR_EN;
  assign PHASE   = state;

  always_comb begin
    state_d = state;
    rinse_d = rinse_cnt;
    abort_d = abort_flag;
    if (ABORT && (state != StIdle) && (state != StDrain)) begin
      state_d = StDrain;
      abort_d = 1'b1;
      rinse_d = 3'd0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start_ok) begin
            state_d = StFill;
            rinse_d = 3'd0;
            abort_d = 1'b0;
          end
        end
        StFill:          if (adv) state_d = (rinse_cnt == 3'd0) ? StWash : StRinse;
        StWash, StRinse: if (adv) state_d = StDrain;
        StDrain: begin
          if (adv) begin
            if (abort_flag) begin
              state_d = StIdle;
              abort_d = 1'b0;
            end else if (rinse_cnt < RinseMax) begin
              state_d = StFill;
              rinse_d = rinse_cnt + 3'd1;
            end else begin
              state_d = StSpin;
            end
          end
        end
        StSpin:          if (adv) state_d = StDone;
        default:         state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    case (state_d)
      StFill:  dur = FILL_T;
      StWash:  dur = WASH_T;
      StDrain: dur = DRAIN_T;
      StRinse: dur = RINSE_T;
      StSpin:  dur = SPIN_T;
      default: dur = 8'd0;
    endcase
  end

  wash_reverser #(
    .REV_T(REV_T)
  ) u_reverser (
    .clk  (CP),
    .rst_n(CLR_),
    .en   (rev_en),
    .clr  (rev_clr),
    .dir  (dir)
  );

  always_ff @(posedge CP or negedge CLR_) begin
    if (!CLR_) begin
      state      <= StIdle;
      rinse_cnt  <= 3'd0;
      abort_flag <= 1'b0;
      TMR_RS     <= 8'd0;
      TMR_LD     <= 1'b0;
      TMR_EN     <= 1'b0;
      WATER_IN   <= 1'b0;
      MOTOR_FWD  <= 1'b0;
      MOTOR_REV  <= 1'b0;
      DRAIN_V    <= 1'b0;
      COMPLETE   <= 1'b0;
`ifdef WASH_LID_LOCK_EN
      LID_LOCK   <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      rinse_cnt  <= rinse_d;
      abort_flag <= abort_d;
      TMR_RS     <= dur;
      TMR_LD     <= (state_d != state) && is_timed(state_d);
      TMR_EN     <= run;
      WATER_IN   <= run && (state_d == StFill);
      DRAIN_V    <= run && ((state_d == StDrain) || (state_d == StSpin));
      MOTOR_FWD  <= run && ((state_d == StRinse) || (state_d == StSpin) ||
                            ((state_d == StWash) && !dir));
      MOTOR_REV  <= run && (state_d == StWash) && dir;
      COMPLETE   <= (state_d == StDone);
`ifdef WASH_LID_LOCK_EN
      LID_LOCK   <= is_timed(state_d);
`endif
    end
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: phase sequence queue plus per-cycle output model,
// with a behavioural phase timer answering TMR_LD/TMR_EN.
module tb_wash_sequencer;

  localparam int RevT = 4;

  logic CP = 1'b0, CLR_ = 1'b1, START = 1'b0, PAUSE = 1'b0, ABORT = 1'b0, TMR_DONE = 1'b0;
  logic [7:0] TMR_RS;
  logic       TMR_LD, TMR_EN, WATER_IN, MOTOR_FWD, MOTOR_REV, DRAIN_V, COMPLETE;
  logic [2:0] PHASE;
`ifdef WASH_LID_LOCK_EN
  logic LID_CLOSED = 1'b1;
  logic LID_LOCK;
`endif

  int         n_vec = 0, n_err = 0, ld_count = 0, rem = 0, wk = 0;
  logic       hold = 1'b0, p_s, run_m, ld_m, found;
  logic [2:0] prev_ph, e_ph;
  logic [3:0] act_m;
  logic [2:0] exp_q[$];

  wash_sequencer #(
    .FILL_T (8'd3),
    .WASH_T (8'd3),
    .RINSE_T(8'd3),
    .SPIN_T (8'd3),
    .DRAIN_T(8'd3),
    .REV_T  (8'(RevT)),
    .RINSES (1)
  ) dut (
    .CP       (CP),
    .CLR_     (CLR_),
    .START    (START),
    .PAUSE    (PAUSE),
    .ABORT    (ABORT),
    .TMR_DONE (TMR_DONE),
`ifdef WASH_LID_LOCK_EN
    .LID_CLOSED(LID_CLOSED),
    .LID_LOCK  (LID_LOCK),
`endif
    .TMR_RS   (TMR_RS),
    .TMR_LD   (TMR_LD),
    .TMR_EN   (TMR_EN),
    .WATER_IN (WATER_IN),
    .MOTOR_FWD(MOTOR_FWD),
    .MOTOR_REV(MOTOR_REV),
    .DRAIN_V  (DRAIN_V),
    .PHASE    (PHASE),
    .COMPLETE (COMPLETE)
  );

  always #5 CP = ~CP;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic timed(input logic [2:0] p);
    return (p >= 3'd1) && (p <= 3'd5);
  endfunction

  function automatic logic [31:0] all_outs();
    return {14'd0, PHASE, TMR_RS, TMR_LD, TMR_EN, WATER_IN, MOTOR_FWD, MOTOR_REV, DRAIN_V,
            COMPLETE};
  endfunction

  task automatic push_seq(input logic [23:0] seq, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(seq[23-3*i -: 3]);
  endtask

  task automatic wait_phase(input logic [2:0] target, input int limit, input string tag);
    int n = 0;
    do begin
      @(negedge CP);
      n++;
    end while (PHASE != target && n < limit);
    check_eq(tag, 32'(PHASE), 32'(target));
  endtask

  task automatic pulse_start();
    @(negedge CP);
    START = 1'b1;
    @(negedge CP);
    START = 1'b0;
  endtask

  // Phase timer: loads on TMR_LD, counts enabled cycles, pulses TMR_DONE on the last one.
  initial begin
    forever begin
      @(posedge CP);
      #1;
      TMR_DONE = 1'b0;
      if (!CLR_) rem = 0;
      else begin
        if (TMR_LD) rem = int'(TMR_RS);
        if (TMR_EN && !hold && rem > 0) begin
          if (rem == 1) TMR_DONE = 1'b1;
          rem--;
        end
      end
    end
  end

  // Monitor: pops the expected phase on every change and models per-cycle outputs.
  initial begin
    prev_ph = 3'd0;
    forever begin
      @(posedge CP);
      p_s = PAUSE;
`ifdef WASH_LID_LOCK_EN
      p_s = p_s || !LID_CLOSED;
`endif
      @(negedge CP);
      if (PHASE != prev_ph) begin
        if (exp_q.size() == 0) check_eq("phase_unexpected", 32'(PHASE), 32'(prev_ph));
        else begin
          e_ph = exp_q.pop_front();
          check_eq("phase_seq", 32'(PHASE), 32'(e_ph));
        end
        if (PHASE == 3'd2) wk = 0;
      end
      ld_m = (PHASE != prev_ph) && timed(PHASE);
      check_eq("tmr_ld", 32'(TMR_LD), 32'(ld_m));
      if (TMR_LD) begin
        ld_count++;
        check_eq("tmr_rs", 32'(TMR_RS), 32'd3);
      end
      run_m = timed(PHASE) && !p_s;
      check_eq("tmr_en", 32'(TMR_EN), 32'(run_m));
      case (PHASE)
        3'd1:    act_m = 4'b1000;
        3'd2:    act_m = (((wk / RevT) % 2) == 1) ? 4'b0001 : 4'b0010;
        3'd3:    act_m = 4'b0100;
        3'd4:    act_m = 4'b0010;
        3'd5:    act_m = 4'b0110;
        default: act_m = 4'b0000;
      endcase
      if (!run_m) act_m = 4'b0000;
      check_eq("actuators", 32'({WATER_IN, DRAIN_V, MOTOR_FWD, MOTOR_REV}), 32'(act_m));
      check_eq("complete", 32'(COMPLETE), 32'(PHASE == 3'd6));
      if (run_m && PHASE == 3'd2) wk++;
      prev_ph = PHASE;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and quiet idle
    #2 CLR_ = 1'b0;
    #1 check_eq("reset_outs", all_outs(), 32'd0);
    repeat (2) @(negedge CP);
    @(posedge CP);
    #3 CLR_ = 1'b1;
    repeat (4) @(negedge CP);
    check_eq("idle_quiet", all_outs(), 32'd0);

    // Nominal programme, one rinse
    push_seq({3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd3, 3'd5, 3'd6}, 8);
    ld_count = 0;
    pulse_start();
    wait_phase(3'd6, 100, "nominal_done");
    check_eq("nominal_complete", 32'(COMPLETE), 32'd1);
    check_eq("nominal_ld_count", 32'(ld_count), 32'd7);
    repeat (3) @(negedge CP);
    check_eq("done_hold_phase", 32'(PHASE), 32'd6);
    check_eq("done_hold_complete", 32'(COMPLETE), 32'd1);

    // Wash reversal with a mid-wash pause, then abort during rinse
    push_seq({3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd3, 3'd0, 3'd0}, 7);
    pulse_start();
    wait_phase(3'd2, 20, "wash_entry");
    hold = 1'b1;
    repeat (20) @(negedge CP);
    ld_count = 0;
    PAUSE = 1'b1;
    repeat (10) @(negedge CP);
    PAUSE = 1'b0;
    repeat (10) @(negedge CP);
    check_eq("pause_no_ld", 32'(ld_count), 32'd0);
    hold = 1'b0;
    wait_phase(3'd4, 100, "rinse_entry");
    ABORT = 1'b1;
    @(negedge CP);
    ABORT = 1'b0;
    check_eq("abort_phase", 32'(PHASE), 32'd3);
    check_eq("abort_ld", 32'(TMR_LD), 32'd1);
    check_eq("abort_rs", 32'(TMR_RS), 32'd3);
    wait_phase(3'd0, 20, "abort_idle");
    check_eq("abort_complete", 32'(COMPLETE), 32'd0);

    // Expiry and pause together in fill, then reset mid-spin
    push_seq({3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd3, 3'd5, 3'd0}, 8);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CP);
      if (TMR_DONE && PHASE == 3'd1) found = 1'b1;
    end
    check_eq("fill_done_seen", 32'(found), 32'd1);
    PAUSE = 1'b1;
    @(negedge CP);
    check_eq("pdone_phase", 32'(PHASE), 32'd2);
    check_eq("pdone_ld", 32'(TMR_LD), 32'd1);
    check_eq("pdone_en", 32'(TMR_EN), 32'd0);
    repeat (4) @(negedge CP);
    check_eq("pdone_en_held", 32'(TMR_EN), 32'd0);
    PAUSE = 1'b0;
    wait_phase(3'd5, 100, "spin_entry");
    @(posedge CP);
    #3 CLR_ = 1'b0;
    #1 check_eq("clr_outs", all_outs(), 32'd0);
    repeat (2) @(negedge CP);
    @(posedge CP);
    #3 CLR_ = 1'b1;
    repeat (5) @(negedge CP);
    check_eq("idle_after_clr", all_outs(), 32'd0);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameters (8-bit durations in CP cycles):
  - FILL_T, 8'd20, fill duration
  - WASH_T, 8'd200, wash duration
  - RINSE_T, 8'd100, rinse duration
  - SPIN_T, 8'd150, spin duration
  - DRAIN_T, 8'd30, drain duration
  - REV_T, 8'd10, wash motor reversal period
  - RINSES, 2, rinse repetitions, range 1..7
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
  - CP  in  1  clock, rising edge
  - CLR_  in  1  asynchronous active-low reset
  - START  in  1  level; begins a programme from IDLE or DONE
  - PAUSE  in  1  level; freezes the current phase
  - ABORT  in  1  level; forces a drain, then IDLE
  - TMR_DONE  in  1  one-cycle expiry pulse from the phase timer
  - TMR_RS  out  8  duration preset for the phase timer
  - TMR_LD  out  1  one-cycle load strobe for the phase timer
  - TMR_EN  out  1  phase timer count enable
  - WATER_IN  out  1  fill valve
  - MOTOR_FWD  out  1  motor forward
  - MOTOR_REV  out  1  motor reverse
  - DRAIN_V  out  1  drain valve
  - PHASE  out  3  current state encoding
  - COMPLETE  out  1  programme finished

Function
REQ-004 States and PHASE encoding: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6. All outputs are registered and update on the rising edge of CP.
REQ-005 Phase sequence: FILL -> WASH -> DRAIN -> (FILL -> RINSE -> DRAIN) x RINSES -> SPIN -> DONE. An internal 3-bit rinse counter selects the successor of DRAIN.
REQ-006 START high in IDLE or DONE -> FILL on the next edge. START is ignored in every other state.
REQ-007 Timer handshake: in the first cycle of every timed state, TMR_LD=1 for exactly one cycle and TMR_RS = that phase's duration. TMR_EN=1 while in a timed state and not paused.
REQ-008 TMR_DONE is acted on only when TMR_EN=1. The phase advances on the edge after TMR_DONE is sampled. TMR_DONE in IDLE or DONE is ignored.
REQ-009 Actuators: WATER_IN=1 in FILL. DRAIN_V=1 in DRAIN and SPIN. MOTOR_FWD=1 in RINSE and SPIN. MOTOR_FWD and MOTOR_REV are never both 1.
REQ-010 WASH motor: MOTOR_FWD/MOTOR_REV alternate every REV_T unpaused cycles, starting with FWD. The internal reversal counter clears on WASH entry.
REQ-011 PAUSE=1 in a timed state: TMR_EN=0 and all actuators 0; state, rinse count and reversal count are held. On PAUSE=0, outputs restore the next cycle with no new TMR_LD.
REQ-012 TMR_DONE and PAUSE in the same cycle: the phase advances, TMR_LD is issued, and the new phase starts paused.
REQ-013 ABORT=1 in any state except IDLE or DRAIN -> DRAIN with a fresh TMR_LD (DRAIN_T). An abort-flag is set and DRAIN exits to IDLE. ABORT has priority over PAUSE, START and TMR_DONE.
REQ-014 COMPLETE=1 only in DONE, held until START.

Reset
REQ-015 CLR_=0 at any time, including mid-phase: state IDLE, all outputs 0, TMR_RS=0, rinse, reversal and abort-flag counters cleared, asynchronously.
REQ-016 After CLR_ is released, no output changes until START.

Configuration
REQ-017 Macro WASH_LID_LOCK_EN.
  - Defined: adds input LID_CLOSED (1 bit) and output LID_LOCK (1 bit). LID_LOCK=1 in every state except IDLE and DONE. START is ignored while LID_CLOSED=0. LID_CLOSED=0 in a timed state behaves as PAUSE.
  - Undefined: neither port exists and behaviour is as above.

Structure
REQ-018 Shared package wash_pkg holds the state encoding constants and the default duration constants.
REQ-019 One sub-module, wash_reverser: the REV_T reversal counter producing the FWD/REV select, with enable and clear inputs.

Verification
REQ-020 Nominal run: RINSES=1, all durations 3, TMR_DONE modelled 3 cycles after each TMR_LD. START -> PHASE 1,2,3,1,4,3,5,6; COMPLETE=1; exactly 7 TMR_LD pulses.
REQ-021 WASH with REV_T=4 -> FWD for 4 cycles, REV for 4 cycles, repeating; FWD and REV never both 1.
REQ-022 PAUSE for 10 cycles mid-WASH -> TMR_EN=0 and actuators 0 for those cycles; motor resumes in the same direction; no extra TMR_LD.
REQ-023 ABORT during RINSE -> next PHASE=3 with TMR_RS=DRAIN_T and TMR_LD=1; after TMR_DONE, PHASE=0 and COMPLETE=0.
REQ-024 CLR_ low mid-SPIN -> all outputs 0 immediately; PHASE stays 0 until START.
REQ-025 TMR_DONE and PAUSE in the same cycle during FILL -> PHASE=2, TMR_LD=1, TMR_EN=0 until PAUSE is released.
